// File: rtl/sys_ctrl_burst_if.sv
// Bus between the system controller and its RX/TX synchronisers, RegFile, ALU and clock gate.
// master = controller side, slave = peripheral/bench side.
interface sys_ctrl_burst_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int ALU_OUT_W = 16,
  parameter int ALU_FUN_W = 4
);
  logic [DATA_W-1:0]    RX_P_DATA;
  logic                 RX_D_VLD;
  logic [DATA_W-1:0]    Rd_data;
  logic                 Rd_data_valid;
  logic [ALU_OUT_W-1:0] ALU_OUT;
  logic                 ALU_OUT_valid;
  logic                 BUSY;
  logic [DATA_W-1:0]    TX_P_DATA;
  logic                 TX_D_VLD;
  logic                 WrEn;
  logic                 RdEn;
  logic [ADDR_W-1:0]    Address;
  logic [DATA_W-1:0]    WrData;
  logic                 ALU_EN;
  logic [ALU_FUN_W-1:0] ALU_FUN;
  logic                 Gate_en;
  logic                 CLK_Div_EN;
  logic                 Cmd_Err;

  modport master (
    input  RX_P_DATA, RX_D_VLD, Rd_data, Rd_data_valid, ALU_OUT, ALU_OUT_valid, BUSY,
    output TX_P_DATA, TX_D_VLD, WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
           Gate_en, CLK_Div_EN, Cmd_Err
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, Rd_data, Rd_data_valid, ALU_OUT, ALU_OUT_valid, BUSY,
    input  TX_P_DATA, TX_D_VLD, WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
           Gate_en, CLK_Div_EN, Cmd_Err
  );
endinterface

// File: rtl/sys_ctrl_burst.sv
// Framed-command system controller with burst RegFile access and a paced response FIFO.
// Command FSM feeds the FIFO; the drain side pops toward TX under BUSY plus a fixed gap.
module sys_ctrl_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int ALU_OUT_W = 16,
  parameter int ALU_FUN_W = 4,
  parameter int TX_DEPTH  = 8,
  parameter int TX_GAP    = 4
) (
  input logic               CLK,
  input logic               rst,
  sys_ctrl_burst_if.master  bus
);
  localparam int NB    = ALU_OUT_W / DATA_W;
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int GAP_W = $clog2(TX_GAP + 1);
  localparam int RW    = $clog2(NB + 1);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(TX_DEPTH);
  localparam logic [PTR_W:0]    NB_C    = (PTR_W+1)'(NB);
  localparam logic [GAP_W-1:0]  GAP_C   = GAP_W'(TX_GAP);
  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'('hAA);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'('hBB);
  localparam logic [DATA_W-1:0] CMD_ALW = DATA_W'('hCC);
  localparam logic [DATA_W-1:0] CMD_ALU = DATA_W'('hDD);
  localparam logic [DATA_W-1:0] CMD_BWR = DATA_W'('hEE);
  localparam logic [DATA_W-1:0] CMD_BRD = DATA_W'('hEF);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN,
    RD_REQ, RD_WAIT, ALU_RUN, ALU_WAIT
  } state_t;
  typedef enum logic [1:0] {K_WR, K_RD, K_BWR, K_BRD} kind_t;

  state_t               state;
  kind_t                kind;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    cnt;
  logic [ALU_OUT_W-1:0] res_sh;
  logic [RW-1:0]        res_left;
  logic                 res_act;

  logic [DATA_W-1:0]    fifo [TX_DEPTH];
  logic [PTR_W-1:0]     wp, rp;
  logic [PTR_W:0]       fcnt;
  logic [GAP_W-1:0]     gap;
  logic                 push, pop, full, room;
  logic [DATA_W-1:0]    push_data;

  assign full = (fcnt == DEPTH_C);
  assign room = ((DEPTH_C - fcnt) >= NB_C);
  assign pop  = (fcnt != '0) && !bus.BUSY && (gap == '0);

  // The first ALU byte is pushed straight off the bus; the rest drain from res_sh.
  always_comb begin
    push      = 1'b0;
    push_data = bus.Rd_data;
    if (state == RD_WAIT && bus.Rd_data_valid) begin
      push = 1'b1;
    end else if (state == ALU_WAIT && res_act) begin
      push      = 1'b1;
      push_data = res_sh[DATA_W-1:0];
    end else if (state == ALU_WAIT && bus.ALU_OUT_valid) begin
      push      = 1'b1;
      push_data = bus.ALU_OUT[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state          <= IDLE;
      kind           <= K_WR;
      addr           <= '0;
      cnt            <= '0;
      res_sh         <= '0;
      res_left       <= '0;
      res_act        <= 1'b0;
      bus.WrEn       <= 1'b0;
      bus.RdEn       <= 1'b0;
      bus.Address    <= '0;
      bus.WrData     <= '0;
      bus.ALU_EN     <= 1'b0;
      bus.ALU_FUN    <= '0;
      bus.Gate_en    <= 1'b0;
      bus.CLK_Div_EN <= 1'b0;
      bus.Cmd_Err    <= 1'b0;
    end else begin
      bus.CLK_Div_EN <= 1'b1;
      bus.WrEn       <= 1'b0;
      bus.RdEn       <= 1'b0;
      bus.ALU_EN     <= 1'b0;
      bus.Cmd_Err    <= bus.RX_D_VLD && (state inside {RD_REQ, RD_WAIT, ALU_RUN, ALU_WAIT});
      case (state)
        IDLE: if (bus.RX_D_VLD) begin
          case (bus.RX_P_DATA)
            CMD_WR:  begin kind <= K_WR;  state <= GET_ADDR; end
            CMD_RD:  begin kind <= K_RD;  state <= GET_ADDR; end
            CMD_BWR: begin kind <= K_BWR; state <= GET_ADDR; end
            CMD_BRD: begin kind <= K_BRD; state <= GET_ADDR; end
            CMD_ALW: state <= GET_A;
            CMD_ALU: state <= GET_FUN;
            default: bus.Cmd_Err <= 1'b1;
          endcase
        end
        GET_ADDR: if (bus.RX_D_VLD) begin
          addr <= bus.RX_P_DATA[ADDR_W-1:0];
          cnt  <= DATA_W'(1);
          case (kind)
            K_WR:    state <= GET_DATA;
            K_RD:    state <= RD_REQ;
            default: state <= GET_CNT;
          endcase
        end
        GET_CNT: if (bus.RX_D_VLD) begin
          cnt <= bus.RX_P_DATA;
          if (bus.RX_P_DATA == '0)  state <= IDLE;
          else if (kind == K_BWR)   state <= GET_DATA;
          else                      state <= RD_REQ;
        end
        GET_DATA: if (bus.RX_D_VLD) begin
          bus.WrEn    <= 1'b1;
          bus.Address <= addr;
          bus.WrData  <= bus.RX_P_DATA;
          addr        <= addr + 1'b1;
          cnt         <= cnt - 1'b1;
          if (cnt == DATA_W'(1)) state <= IDLE;
        end
        GET_A: if (bus.RX_D_VLD) begin
          bus.WrEn    <= 1'b1;
          bus.Address <= '0;
          bus.WrData  <= bus.RX_P_DATA;
          state       <= GET_B;
        end
        GET_B: if (bus.RX_D_VLD) begin
          bus.WrEn    <= 1'b1;
          bus.Address <= ADDR_W'(1);
          bus.WrData  <= bus.RX_P_DATA;
          state       <= GET_FUN;
        end
        GET_FUN: if (bus.RX_D_VLD) begin
          bus.ALU_FUN <= bus.RX_P_DATA[ALU_FUN_W-1:0];
          bus.Gate_en <= 1'b1;
          state       <= ALU_RUN;
        end
        RD_REQ: if (!full) begin
          bus.RdEn    <= 1'b1;
          bus.Address <= addr;
          state       <= RD_WAIT;
        end
        RD_WAIT: if (bus.Rd_data_valid) begin
          addr  <= addr + 1'b1;
          cnt   <= cnt - 1'b1;
          state <= (cnt == DATA_W'(1)) ? IDLE : RD_REQ;
        end
        // Hold off the ALU until every result byte is guaranteed a FIFO slot.
        ALU_RUN: if (room) begin
          bus.ALU_EN <= 1'b1;
          state      <= ALU_WAIT;
        end
        ALU_WAIT: begin
          if (res_act) begin
            res_sh   <= res_sh >> DATA_W;
            res_left <= res_left - 1'b1;
            if (res_left == RW'(1)) begin
              res_act <= 1'b0;
              state   <= IDLE;
            end
          end else if (bus.ALU_OUT_valid) begin
            bus.Gate_en <= 1'b0;
            if (NB == 1) begin
              state <= IDLE;
            end else begin
              res_sh   <= bus.ALU_OUT >> DATA_W;
              res_left <= RW'(NB - 1);
              res_act  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo[wp] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wp            <= '0;
      rp            <= '0;
      fcnt          <= '0;
      gap           <= '0;
      bus.TX_D_VLD  <= 1'b0;
      bus.TX_P_DATA <= '0;
    end else begin
      bus.TX_D_VLD <= pop;
      if (pop) begin
        bus.TX_P_DATA <= fifo[rp];
        rp            <= rp + 1'b1;
        gap           <= GAP_C;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (push) wp <= wp + 1'b1;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end
endmodule
